// File: rtl/gvp_program_sequencer.sv
// rtl/gvp_program_sequencer.sv - GVP config-bus sequencer with vector program store
module gvp_program_sequencer #(
    parameter int NUM_VECTORS_N2                 = 4,
    parameter int NUM_VECTORS                    = 2**NUM_VECTORS_N2,
    parameter int control_reg_address            = 1,
    parameter int reset_options_reg_address      = 2,
    parameter int vector_programming_reg_address = 3,
    parameter int vector_preset_address          = 4,
    parameter int HOLD_CYCLES                    = 8,
    parameter int GAP_CYCLES                     = 2,
    parameter int ARM_CYCLES                     = 12
) (
    input  logic                      a_clk,
    input  logic                      reset,
    input  logic [511:0]              s_vec_tdata,
    input  logic                      s_vec_tvalid,
    output logic                      s_vec_tready,
    input  logic                      prog_clear,
    input  logic [15:0]               reset_options,
    input  logic [95:0]               preset_uab,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      pause_req,
    input  logic                      gvp_finished,
    output logic [31:0]               config_addr,
    output logic [511:0]              config_data,
    output logic [NUM_VECTORS_N2:0]   vec_count,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int CW = NUM_VECTORS_N2 + 1;
    localparam logic [CW-1:0] FULL      = CW'(NUM_VECTORS);
    localparam logic [15:0]   HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0]   WR_LAST   = 16'(HOLD_CYCLES + GAP_CYCLES - 1);
    localparam logic [15:0]   ARM_LAST  = 16'(ARM_CYCLES - 1);
    localparam logic [31:0]   A_CTRL    = 32'(control_reg_address);
    localparam logic [31:0]   A_OPTS    = 32'(reset_options_reg_address);
    localparam logic [31:0]   A_VEC     = 32'(vector_programming_reg_address);
    localparam logic [31:0]   A_PRE     = 32'(vector_preset_address);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_OPTS, S_VEC, S_TERM, S_PRE, S_REL,
        S_ARM, S_RUN, S_PAUSE, S_ABORT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     addr_q, addr_d;
    logic [511:0]    data_q, data_d;
    logic            tready_q, tready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            pause_q, pause_d;
    logic            fin_prev_q;
    logic            launch, idle_like, push, wr_end;
    logic [511:0]    vec_rd;
    logic [511:0]    vec_mem [NUM_VECTORS];

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign push      = s_vec_tvalid && tready_q && !prog_clear;
    assign wr_end    = (cnt_q == WR_LAST);
    assign vec_rd    = vec_mem[idx_d[NUM_VECTORS_N2-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = err_q;
        pause_d = pause_q;
        launch  = 1'b0;

        if (idle_like) begin
            if (prog_clear) begin
                count_d = '0;
                err_d   = 1'b0;
            end else if (push) begin
                count_d = count_q + 1'b1;
            end else if (s_vec_tvalid && count_q == FULL) begin
                err_d = 1'b1;
            end
            if (start) begin
                if (prog_clear || count_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_RST;
                    launch  = 1'b1;
                end
            end
        end else if (abort && state_q != S_ABORT) begin
            state_d = S_ABORT;
            launch  = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
            // The bus goes idle after the hold window; data stays for the gap.
            if (cnt_q == HOLD_LAST) addr_d = '0;
            case (state_q)
                S_RST:   if (wr_end) begin state_d = S_OPTS; launch = 1'b1; end
                S_OPTS:  if (wr_end) begin state_d = S_VEC; idx_d = '0; launch = 1'b1; end
                S_VEC: begin
                    if (wr_end) begin
                        launch = 1'b1;
                        if (idx_q + 1'b1 < count_q) idx_d = idx_q + 1'b1;
                        else if (count_q != FULL)   state_d = S_TERM;
                        else                        state_d = S_PRE;
                    end
                end
                S_TERM:  if (wr_end) begin state_d = S_PRE; launch = 1'b1; end
                S_PRE:   if (wr_end) begin state_d = S_REL; launch = 1'b1; end
                S_REL:   if (wr_end) begin state_d = S_ARM; launch = 1'b1; end
                S_ARM:   if (cnt_q == ARM_LAST) state_d = S_RUN;
                S_RUN: begin
                    if (gvp_finished && !fin_prev_q) begin
                        state_d = S_DONE;
                    end else if (pause_req != pause_q) begin
                        state_d = S_PAUSE;
                        launch  = 1'b1;
                    end
                end
                S_PAUSE: if (wr_end) state_d = S_RUN;
                S_ABORT: if (wr_end) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (launch) begin
            cnt_d = '0;
            case (state_d)
                S_RST, S_ABORT: begin
                    addr_d    = A_CTRL;
                    data_d    = '0;
                    data_d[0] = 1'b1;
                end
                S_OPTS: begin
                    addr_d = A_OPTS;
                    data_d = 512'(reset_options);
                end
                S_VEC: begin
                    addr_d       = A_VEC;
                    data_d       = vec_rd;
                    data_d[31:0] = 32'(idx_d);
                end
                S_TERM: begin
                    addr_d       = A_VEC;
                    data_d       = '0;
                    data_d[31:0] = 32'(count_q);
                end
                S_PRE: begin
                    addr_d         = A_PRE;
                    data_d         = '0;
                    data_d[191:96] = preset_uab;
                end
                S_REL, S_PAUSE: begin
                    addr_d    = A_CTRL;
                    data_d    = '0;
                    data_d[1] = pause_req;
                    pause_d   = pause_req;
                end
                default: addr_d = '0;
            endcase
        end

        tready_d = (state_d == S_IDLE || state_d == S_DONE) && count_d != FULL;
        busy_d   = !(state_d == S_IDLE || state_d == S_DONE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pause_q    <= 1'b0;
            fin_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pause_q    <= pause_d;
            fin_prev_q <= gvp_finished;
        end
    end

    // Program store: contents survive reset, only the fill count is cleared.
    always_ff @(posedge a_clk) begin
        if (push) vec_mem[count_q[NUM_VECTORS_N2-1:0]] <= s_vec_tdata;
    end

    assign config_addr  = addr_q;
    assign config_data  = data_q;
    assign s_vec_tready = tready_q;
    assign vec_count    = count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gvp_program_sequencer.sv
// tb/tb_gvp_program_sequencer.sv - directed self-checking bench for gvp_program_sequencer
module tb_gvp_program_sequencer;

    logic         a_clk = 1'b0;
    logic         reset;
    logic [511:0] s_vec_tdata;
    logic         s_vec_tvalid;
    logic         s_vec_tready;
    logic         prog_clear;
    logic [15:0]  reset_options;
    logic [95:0]  preset_uab;
    logic         start;
    logic         abort;
    logic         pause_req;
    logic         gvp_finished;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic [4:0]   vec_count;
    logic         busy;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [95:0] PRESET = 96'h0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [15:0] OPTS   = 16'hBEEF;

    always #5 a_clk = ~a_clk;

    gvp_program_sequencer dut (
        .a_clk(a_clk), .reset(reset),
        .s_vec_tdata(s_vec_tdata), .s_vec_tvalid(s_vec_tvalid), .s_vec_tready(s_vec_tready),
        .prog_clear(prog_clear), .reset_options(reset_options), .preset_uab(preset_uab),
        .start(start), .abort(abort), .pause_req(pause_req), .gvp_finished(gvp_finished),
        .config_addr(config_addr), .config_data(config_data), .vec_count(vec_count),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_blk(input int i);
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[j*32 +: 32] = {8'(i), 8'hC3, 16'(j*7 + 1)};
        return b;
    endfunction

    function automatic logic [511:0] vec_exp(input int k);
        logic [511:0] b;
        b = mk_blk(k);
        b[31:0] = 32'(k);
        return b;
    endfunction

    // Called at the negedge where the write first shows; returns at the negedge after its gap.
    task automatic expect_write(input string tag, input logic [31:0] a, input logic [511:0] d,
                                input bit tog);
        int hold = 0;
        int gap  = 0;
        for (int i = 0; i < 8; i++) begin
            if (config_addr === a && config_data === d && busy === 1'b1) hold++;
            if (tog && i == 2) pause_req = 1'b1;
            if (tog && i == 4) pause_req = 1'b0;
            if (tog && i == 6) pause_req = 1'b1;
            @(negedge a_clk);
        end
        for (int i = 0; i < 2; i++) begin
            if (config_addr === 32'd0 && config_data === d && busy === 1'b1) gap++;
            @(negedge a_clk);
        end
        check({tag, "_hold"}, 512'(hold), 512'd8);
        check({tag, "_gap"}, 512'(gap), 512'd2);
    endtask

    task automatic push_blocks(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_vec_tvalid = 1'b1;
            s_vec_tdata  = mk_blk(base + i);
            @(negedge a_clk);
        end
        s_vec_tvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] pre_exp;
        int cnt;
        pre_exp = '0;
        pre_exp[191:96] = PRESET;

        reset = 1'b1; s_vec_tdata = '0; s_vec_tvalid = 1'b0; prog_clear = 1'b0;
        reset_options = OPTS; preset_uab = PRESET; start = 1'b0; abort = 1'b0;
        pause_req = 1'b0; gvp_finished = 1'b0;
        repeat (2) @(negedge a_clk);
        check("rst_addr", 512'(config_addr), '0);
        check("rst_data", config_data, '0);
        check("rst_flags", 512'({s_vec_tready, vec_count, busy, done, err}), '0);
        reset = 1'b0;
        @(negedge a_clk);
        check("idle_tready", 512'(s_vec_tready), 512'd1);

        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        check("idle_abort_ignored", 512'({busy, config_addr}), '0);

        pulse_start();
        check("empty_start_err", 512'(err), 512'd1);
        check("empty_start_idle", 512'({busy, config_addr}), '0);

        push_blocks(3, 0);
        check("count3", 512'(vec_count), 512'd3);
        check("err_sticky", 512'(err), 512'd1);

        pulse_start();
        check("start_err_clr", 512'(err), 512'd0);
        check("start_busy", 512'(busy), 512'd1);
        expect_write("rst", 32'd1, 512'h1, 1'b0);
        expect_write("opts", 32'd2, 512'(OPTS), 1'b0);
        for (int k = 0; k < 3; k++) expect_write($sformatf("vec%0d", k), 32'd3, vec_exp(k), 1'b0);
        expect_write("term", 32'd3, 512'd3, 1'b0);
        expect_write("pre", 32'd4, pre_exp, 1'b0);
        expect_write("rel", 32'd1, 512'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (config_addr === 32'd0 && busy === 1'b1 && done === 1'b0) cnt++;
            @(negedge a_clk);
        end
        check("arm", 512'(cnt), 512'd12);

        pause_req = 1'b1;
        @(negedge a_clk);
        expect_write("pause1", 32'd1, 512'h2, 1'b0);
        pause_req = 1'b0;
        @(negedge a_clk);
        expect_write("pause0", 32'd1, 512'h0, 1'b1);
        @(negedge a_clk);
        expect_write("pause_last", 32'd1, 512'h2, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (config_addr === 32'd0) cnt++;
            @(negedge a_clk);
        end
        check("run_quiet", 512'(cnt), 512'd20);

        gvp_finished = 1'b1;
        @(negedge a_clk);
        check("fin_done", 512'({done, busy}), 512'b10);
        check("fin_addr", 512'(config_addr), '0);
        check("fin_tready", 512'(s_vec_tready), 512'd1);
        gvp_finished = 1'b0;

        pulse_start();
        expect_write("rerun_rst", 32'd1, 512'h1, 1'b0);
        expect_write("rerun_opts", 32'd2, 512'(OPTS), 1'b0);
        expect_write("rerun_vec0", 32'd3, vec_exp(0), 1'b0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (config_addr === 32'd3 && config_data === vec_exp(1)) cnt++;
            @(negedge a_clk);
        end
        check("rerun_vec1", 512'(cnt), 512'd3);
        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        expect_write("abort", 32'd1, 512'h1, 1'b0);
        check("abort_idle", 512'({busy, done, config_addr}), '0);
        check("abort_count", 512'(vec_count), 512'd3);

        pulse_start();
        repeat (13) @(negedge a_clk);
        #2 reset = 1'b1;
        #1;
        check("async_addr", 512'(config_addr), '0);
        check("async_data", config_data, '0);
        check("async_flags", 512'({s_vec_tready, vec_count, busy, done, err}), '0);
        @(negedge a_clk);
        reset = 1'b0;
        @(negedge a_clk);

        s_vec_tvalid = 1'b1; s_vec_tdata = mk_blk(9); prog_clear = 1'b1;
        @(negedge a_clk);
        s_vec_tvalid = 1'b0; prog_clear = 1'b0;
        check("clear_prio", 512'(vec_count), '0);

        push_blocks(16, 0);
        check("full_count", 512'(vec_count), 512'd16);
        check("full_tready", 512'(s_vec_tready), '0);
        s_vec_tvalid = 1'b1; s_vec_tdata = mk_blk(40);
        @(negedge a_clk);
        s_vec_tvalid = 1'b0;
        check("overflow_err", 512'(err), 512'd1);
        check("overflow_count", 512'(vec_count), 512'd16);

        pulse_start();
        check("full_start_err", 512'(err), '0);
        expect_write("f_rst", 32'd1, 512'h1, 1'b0);
        expect_write("f_opts", 32'd2, 512'(OPTS), 1'b0);
        for (int k = 0; k < 16; k++) expect_write($sformatf("f_vec%0d", k), 32'd3, vec_exp(k), 1'b0);
        expect_write("f_pre_no_term", 32'd4, pre_exp, 1'b0);
        expect_write("f_rel", 32'd1, 512'h2, 1'b0);
        repeat (3) @(negedge a_clk);
        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        expect_write("f_abort", 32'd1, 512'h1, 1'b0);
        check("f_abort_idle", 512'(busy), '0);

        prog_clear = 1'b1;
        @(negedge a_clk);
        prog_clear = 1'b0;
        check("prog_clear", 512'({vec_count, err}), '0);
        check("prog_clear_tready", 512'(s_vec_tready), 512'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gvp_program_sequencer.md
Name: gvp_program_sequencer

Overview:
- Sequences the General Vector Program core through its configuration bus (config_addr/config_data).
- Stores a vector program pushed by the PS over an AXI-Stream-style port.
- On start: holds the GVP in reset, writes reset options, every vector block and the U/A/B presets, then releases reset, forwards pause changes and watches gvp_finished.
- Sits between the PS config/DMA path and the GVP core; it is the only master of the GVP config bus.

Parameters:
- NUM_VECTORS_N2, 4, log2 of vector slots.
- NUM_VECTORS, 16, vector slots held (= 2**NUM_VECTORS_N2).
- control_reg_address, 1, GVP control register address (bit0 reset, bit1 pause).
- reset_options_reg_address, 2, GVP reset-options address.
- vector_programming_reg_address, 3, GVP vector-write address.
- vector_preset_address, 4, GVP preset address.
- HOLD_CYCLES, 8, cycles each config word is held on the bus (≥2; must exceed the slowest GVP decimation tick used during load).
- GAP_CYCLES, 2, cycles of config_addr=0 between writes.
- ARM_CYCLES, 12, wait after reset release before entering RUN (covers the GVP 10-stage reset pipe).

Ports:
- a_clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- s_vec_tdata, in, 512, vector block [N, NII, Options, Nrep, Next, dx..db, ..., deci] in GVP layout; word0 is ignored.
- s_vec_tvalid, in, 1, block valid.
- s_vec_tready, out, 1, block accepted when tvalid&&tready.
- prog_clear, in, 1, pulse: empty the vector store (IDLE/DONE only).
- reset_options, in, 16, value for the reset-options write.
- preset_uab, in, 96, {B,A,U} preset values.
- start, in, 1, pulse: run the load-and-execute sequence.
- abort, in, 1, pulse: force the GVP back into reset.
- pause_req, in, 1, level: requested pause state while running.
- gvp_finished, in, 1, GVP finished flag.
- config_addr, out, 32, GVP config address.
- config_data, out, 512, GVP config data.
- vec_count, out, NUM_VECTORS_N2+1, number of stored blocks.
- busy, out, 1, high in any state except IDLE/DONE.
- done, out, 1, high in DONE.
- err, out, 1, sticky: start with vec_count==0 or push while full; cleared by the next accepted start or prog_clear.

Behaviour:
- Reset values: config_addr=0, config_data=0, s_vec_tready=0, vec_count=0, busy=0, done=0, err=0. All outputs are registered.
- Load:
  - tready=1 only in IDLE/DONE and vec_count<NUM_VECTORS.
  - An accepted block goes to slot vec_count; vec_count increments.
  - tvalid while full in IDLE/DONE sets err; the block is dropped.
  - prog_clear has priority over a same-cycle push.
- States:
  - IDLE→RST on start (if vec_count==0: set err, stay).
  - RST: write control={reset=1, pause=0}.
  - OPTS: write reset_options zero-extended.
  - VEC(k), k=0..vec_count-1: write slot k with bits[31:0] replaced by k.
  - TERM: write one extra block with all-zero data and word0=vec_count (N=0 end mark), only if vec_count<NUM_VECTORS.
  - PRE: write preset_uab into config_data[191:96], other bits 0.
  - REL: write control={reset=0, pause=pause_req}.
  - ARM: wait ARM_CYCLES.
  - RUN → DONE.
- Every write = HOLD_CYCLES with addr/data driven, then GAP_CYCLES with config_addr=0 and data held.
- RUN:
  - gvp_finished rising edge → DONE.
  - A pause_req change issues one control write {reset=0, pause=new}. A change during that write is re-evaluated after its gap; last value wins.
- DONE: GVP left running and finished. Start re-runs from RST; stored vectors are retained.
- abort in any busy state: the current write is truncated; next cycle enters RST-only, holding control={reset=1} for HOLD+GAP, then IDLE. abort is ignored in IDLE/DONE.
- start while busy is ignored.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
- Push 3 blocks, start → addr sequence 1,0,2,0,3(k=0),0,3(1),0,3(2),0,3(term, N=0),0,4,0,1(data bit0=0). Each write lasts 8 cycles with 2-cycle gaps. busy=1 throughout; RUN after 12 ARM cycles.
- In RUN, assert gvp_finished → done=1, busy=0 next cycle, config_addr stays 0.
- In RUN, toggle pause_req 0→1 → one control write with data[1:0]=2'b10. Toggling 1→0→1 inside that write → exactly one further write with pause=1.
- Push 16 blocks, push a 17th → tready=0, err=1, vec_count=16, no TERM write on start.
- Start with empty store → err=1, stays IDLE, config_addr=0.
- abort during VEC(1) → within 1 cycle config_addr=1 with data bit0=1 for 8 cycles, then gap, then IDLE; asserting reset mid-load zeroes all outputs immediately.
